// File: rtl/multi_mode_seq_counter.sv
// WIDTH-bit sequence counter with Johnson, ring, binary and Gray modes.
// It supports up/down stepping, parallel load, a wrap pulse and illegal-state self-correction.
module multi_mode_seq_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] d,
  output logic             wrap,
  output logic             err
);

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_BINARY  = 2'b10;
  localparam logic [1:0] MODE_GRAY    = 2'b11;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [1:0]       mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] johnson_next_s;
  logic [WIDTH-1:0] ring_next_s;
  logic [WIDTH-1:0] binary_next_s;
  logic [WIDTH-1:0] bin_next_s;
  logic [WIDTH-1:0] gray_next_s;
  logic [WIDTH-1:0] step_next_s;
  logic             legal_s;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ {1'b0, b[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] mode_seed(input logic [1:0] m);
    logic [WIDTH-1:0] s;
    case (m)
      MODE_RING: s = ONE_W;
      default:   s = ZERO_W;
    endcase
    return s;
  endfunction

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != ZERO_W) && ((v & (v - ONE_W)) == ZERO_W);
  endfunction

  // True for 0*1* patterns (a contiguous run of ones anchored at bit 0, or zero)
  function automatic logic is_low_mask(input logic [WIDTH-1:0] v);
    return (v & (v + ONE_W)) == ZERO_W;
  endfunction

  function automatic logic is_legal(input logic [1:0] m, input logic [WIDTH-1:0] v);
    logic ok;
    case (m)
      MODE_JOHNSON: ok = is_low_mask(v) || is_low_mask(~v);
      MODE_RING:    ok = is_onehot(v);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign johnson_next_s = dir ? {state_q[WIDTH-2:0], ~state_q[WIDTH-1]}
                              : {~state_q[0], state_q[WIDTH-1:1]};
  assign ring_next_s    = dir ? {state_q[WIDTH-2:0], state_q[WIDTH-1]}
                              : {state_q[0], state_q[WIDTH-1:1]};
  assign binary_next_s  = dir ? (state_q - ONE_W) : (state_q + ONE_W);
  assign bin_next_s     = dir ? (bin_q - ONE_W) : (bin_q + ONE_W);
  assign gray_next_s    = bin2gray(bin_next_s);
  assign legal_s        = is_legal(mode_q, state_q);

  // Select the stepped value for the currently latched mode
  always_comb begin
    step_next_s = state_q;
    case (mode_q)
      MODE_JOHNSON: step_next_s = johnson_next_s;
      MODE_RING:    step_next_s = ring_next_s;
      MODE_BINARY:  step_next_s = binary_next_s;
      MODE_GRAY:    step_next_s = gray_next_s;
      default:      step_next_s = state_q;
    endcase
  end

  // Next-state resolution: load beats mode change beats step beats hold
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      state_d = load_val;
      mode_d  = mode;
      if (mode == MODE_GRAY) begin
        bin_d = gray2bin(load_val);
      end else begin
        bin_d = bin_q;
      end
    end else if (mode != mode_q) begin
      state_d = mode_seed(mode);
      mode_d  = mode;
      bin_d   = ZERO_W;
    end else if (en) begin
      if (!legal_s) begin
        state_d = mode_seed(mode_q);
        bin_d   = ZERO_W;
        err_d   = 1'b1;
      end else begin
        state_d = step_next_s;
        if (mode_q == MODE_GRAY) begin
          bin_d = bin_next_s;
        end else begin
          bin_d = bin_q;
        end
        wrap_d = (step_next_s == mode_seed(mode_q));
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, mode, Gray shadow register and pulse flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ZERO_W;
      bin_q   <= ZERO_W;
      mode_q  <= MODE_JOHNSON;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign d    = state_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_multi_mode_seq_counter.sv
// Directed table-driven bench for multi_mode_seq_counter at WIDTH=5.
// Hand-written sequences cover Gray single-bit stepping and asynchronous reset mid-count.
module tb_multi_mode_seq_counter;

  localparam int W = 5;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic [1:0]   md;
    logic         dr;
    logic         e;
    logic [W-1:0] xd;
    logic         xw;
    logic         xe;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] d;
  logic         wrap;
  logic         err;

  int   passed;
  int   total;
  vec_t vq[$];

  multi_mode_seq_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .d(d), .wrap(wrap), .err(err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic add(input logic ld, input logic [W-1:0] lv, input logic [1:0] md,
                     input logic dr, input logic e, input logic [W-1:0] xd,
                     input logic xw, input logic xe);
    vec_t v;
    v.ld = ld; v.lv = lv; v.md = md; v.dr = dr; v.e = e;
    v.xd = xd; v.xw = xw; v.xe = xe;
    vq.push_back(v);
  endtask

  task automatic apply(input logic ld, input logic [W-1:0] lv, input logic [1:0] md,
                       input logic dr, input logic e);
    load = ld; load_val = lv; mode = md; dir = dr; en = e;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] prev_d;
  logic [W-1:0] gray_exp[4];
  logic [W-1:0] diff;

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; load = 1'b0; load_val = 5'b00000;

    // Johnson up from reset
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b11000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b11100, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b11110, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b11111, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b01111, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b00111, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b00011, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0);
    // Mode change to ring: reseed, no step, then ring right
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b01000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b00100, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b00010, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b00001, 1'b1, 1'b0);
    // Ring left
    add(1'b0, 5'b00000, 2'b01, 1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b1, 1'b1, 5'b00100, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b1, 1'b1, 5'b01000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b1, 1'b1, 5'b10000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0);
    // Hold
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b0, 5'b00001, 1'b0, 1'b0);
    // Binary: load 1, count down through zero, then up
    add(1'b1, 5'b00001, 2'b10, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b10, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b0);
    add(1'b0, 5'b00000, 2'b10, 1'b1, 1'b1, 5'b11111, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b10, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0);
    add(1'b0, 5'b00000, 2'b10, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b0);
    // Ring illegal load then correction
    add(1'b1, 5'b01010, 2'b01, 1'b0, 1'b1, 5'b01010, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1);
    add(1'b0, 5'b00000, 2'b01, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b0);
    // Johnson illegal load: correction to seed raises err but never wrap
    add(1'b1, 5'b10101, 2'b00, 1'b0, 1'b1, 5'b10101, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b1);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b0);
    // Johnson left from seed
    add(1'b0, 5'b00000, 2'b00, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b0);
    // Legal Johnson load then step right
    add(1'b1, 5'b11100, 2'b00, 1'b0, 1'b1, 5'b11100, 1'b0, 1'b0);
    add(1'b0, 5'b00000, 2'b00, 1'b0, 1'b1, 5'b11110, 1'b0, 1'b0);

    #12;
    check("reset_d", d, 5'b00000);
    check("reset_wrap", {4'b0000, wrap}, 5'b00000);
    check("reset_err", {4'b0000, err}, 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].ld, vq[i].lv, vq[i].md, vq[i].dr, vq[i].e);
      check($sformatf("vec%0d_d", i), d, vq[i].xd);
      check($sformatf("vec%0d_wrap", i), {4'b0000, wrap}, {4'b0000, vq[i].xw});
      check($sformatf("vec%0d_err", i), {4'b0000, err}, {4'b0000, vq[i].xe});
    end

    // Gray: load 00110 (b=4), step up with single-bit changes
    gray_exp[0] = 5'b00111; gray_exp[1] = 5'b00101;
    gray_exp[2] = 5'b00100; gray_exp[3] = 5'b01100;
    apply(1'b1, 5'b00110, 2'b11, 1'b0, 1'b1);
    check("gray_load", d, 5'b00110);
    for (int i = 0; i < 4; i++) begin
      prev_d = d;
      apply(1'b0, 5'b00000, 2'b11, 1'b0, 1'b1);
      check($sformatf("gray_step%0d", i), d, gray_exp[i]);
      diff = d ^ prev_d;
      check($sformatf("gray_onebit%0d", i), {4'b0000, $onehot(diff)}, 5'b00001);
    end
    apply(1'b0, 5'b00000, 2'b11, 1'b1, 1'b1);
    check("gray_reverse", d, 5'b00100);

    // Gray wrap on down-count to zero, then asynchronous reset while wrap is high
    apply(1'b1, 5'b00001, 2'b11, 1'b1, 1'b1);
    apply(1'b0, 5'b00000, 2'b11, 1'b1, 1'b1);
    check("gray_wrap_d", d, 5'b00000);
    check("gray_wrap", {4'b0000, wrap}, 5'b00001);
    apply(1'b0, 5'b00000, 2'b11, 1'b1, 1'b1);
    check("gray_under_d", d, 5'b10000);
    load = 1'b1; load_val = 5'b01111; en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_d", d, 5'b00000);
    check("async_rst_wrap", {4'b0000, wrap}, 5'b00000);
    check("async_rst_err", {4'b0000, err}, 5'b00000);
    @(negedge clk);
    load = 1'b0; mode = 2'b11; dir = 1'b0; en = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_reseed_d", d, 5'b00000);
    check("post_rst_reseed_wrap", {4'b0000, wrap}, 5'b00000);
    apply(1'b0, 5'b00000, 2'b11, 1'b0, 1'b1);
    check("post_rst_step", d, 5'b00001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_mode_seq_counter.md
Name: multi_mode_seq_counter

Overview:
- Parametrised successor to the 5-bit Johnson/ring counter: WIDTH-bit sequence counter with four runtime-selectable modes (Johnson, ring, binary, Gray).
- Adds bidirectional counting, count enable, synchronous parallel load, a wrap pulse, and illegal-state detection with self-correction.
- Used as a general sequence/phase generator; all outputs are registered.

Parameters:
- WIDTH, 5, counter width in bits; legal range 2..16.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; one step per cycle while high.
- mode  in  2  00 Johnson, 01 ring, 10 binary, 11 Gray.
- dir  in  1  0 = shift right / count up; 1 = shift left / count down.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- d  out  WIDTH  counter state.
- wrap  out  1  one-cycle pulse: count step returned d to the mode seed.
- err  out  1  one-cycle pulse: step taken from an illegal state, seed restored.

Behaviour:
- Seeds: Johnson 0, ring 1 (bit 0 set), binary 0, Gray 0.
- Reset (rst_n low, asynchronous):
  - d = 0 (Johnson seed, since mode_q resets to 00).
  - Internal binary register = 0; mode_q = 00.
  - wrap = 0, err = 0.
- Priority at each edge: load > mode change (mode != mode_q) > en step > hold.
- wrap and err default to 0 every cycle and are high only as stated below.
- load:
  - d <= load_val; mode_q <= mode.
  - In Gray mode, the internal binary register <= gray-to-binary(load_val).
  - No validity check at load.
- Mode change (no load):
  - d <= seed of the new mode; mode_q <= mode; internal binary register <= 0.
  - No step is taken that cycle.
- Johnson step (en=1):
  - dir=0: d <= {~d[0], d[W-1:1]}.
  - dir=1: d <= {d[W-2:0], ~d[W-1]}.
  - Period 2*WIDTH.
- Ring step:
  - dir=0: d <= {d[0], d[W-1:1]}.
  - dir=1: d <= {d[W-2:0], d[W-1]}.
  - Period WIDTH.
- Binary step:
  - dir=0: d <= d+1; dir=1: d <= d-1.
  - Modulo 2^WIDTH; wraps silently except for the wrap flag.
- Gray step:
  - Internal binary b <= b±1 per dir.
  - d <= next_b ^ (next_b >> 1).
  - Exactly one bit of d changes per step.
- Legality:
  - Ring: d must be one-hot.
  - Johnson: d must be a thermometer pattern, MSB-to-LSB, of the form 1*0* or 0*1*.
  - Binary and Gray: always legal.
- Illegal-state step: if en=1 and the state is illegal, d <= mode seed instead of stepping, and err is high the next cycle. This also applies to the Gray internal register. No wrap.
- wrap rule: high for the cycle after an en-step whose result equals the seed.
  - Includes down-count: binary 0 -> 2^W-1 does NOT wrap; 1 -> 0 does.
  - Never set by load, mode change, reset or illegal-state correction.
- en=0: d holds; wrap=0; err=0.
- dir may change any cycle and takes effect on the next step. Reversal retraces the sequence exactly.
- Reset mid-sequence: immediate asynchronous clear; the sequence restarts from the Johnson seed after rst_n releases.

Test Plan:
- Johnson, WIDTH=5, dir=0, en=1 from reset:
  - d = 10000, 11000, 11100, 11110, 11111, 01111, 00111, 00011, 00001, 00000.
  - wrap high only after the 10th step.
- mode 00->01 with en=1:
  - Next edge d=00001 (no step), then 10000, 01000, 00100, 00010, 00001.
  - wrap after the 5th step.
  - With dir=1, from 00001: 00010, 00100, ...
- Binary, dir=1, load load_val=00001, en=1:
  - d=00000 with wrap, then 11111 with no wrap.
  - Switch to dir=0: d=00000 with wrap again.
- Gray, load 00110 (binary 4), en=1, dir=0:
  - d = 00111, 00101, 00100, 01100 (b = 5, 6, 7, 8).
  - Check a single-bit change on every step.
- Ring, load 01010 (illegal), en=1:
  - Next edge d=00001 and err=1 for one cycle; wrap=0; stepping then resumes normally.
  - Johnson, load 10101: same correction to 00000 with err.
- Assert rst_n low asynchronously mid-count in Gray mode with load=1 and en=1:
  - d=0, wrap=0, err=0 immediately; mode_q=00.
  - After release with mode=11, first edge reseeds (mode change) with d=0 and no step.
